memory_request_buffer: RTL and testbench

Decoupling buffer between the MMU interface's memory port and the external memory bus. It queues up to `P_REQ_DEPTH` read/write requests and issues them to memory in order. It tracks outstanding reads and holds returned 64-bit read data in a return FIFO. Read issue is credit-limited, so returned data can never be dropped.

---
 rtl/memory_request_buffer.sv | 126 ++++++++++++
 tb/tb_memory_request_buffer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_request_buffer.sv
// Decoupling buffer between the MMU memory port and the external memory bus:
// in-order request FIFO, credit-limited read issue and a read-return FIFO.
module memory_request_buffer #(
  parameter int P_REQ_DEPTH = 4,
  parameter int P_RD_DEPTH  = 4
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iREQ,
  output logic        oLOCK,
  input  logic [1:0]  iORDER,
  input  logic        iRW,
  input  logic [31:0] iADDR,
  input  logic [31:0] iDATA,
  output logic        oVALID,
  input  logic        iBUSY,
  output logic [63:0] oDATA,
  output logic        oSTORE_ACK,
  output logic        oMEMORY_REQ,
  input  logic        iMEMORY_LOCK,
  output logic [1:0]  oMEMORY_ORDER,
  output logic        oMEMORY_RW,
  output logic [31:0] oMEMORY_ADDR,
  output logic [31:0] oMEMORY_DATA,
  input  logic        iMEMORY_VALID,
  output logic        oMEMORY_BUSY,
  input  logic [63:0] iMEMORY_DATA,
  output logic        oERR
);

  localparam int RQ_AW = $clog2(P_REQ_DEPTH);
  localparam int RD_AW = $clog2(P_RD_DEPTH);
  localparam logic [RQ_AW:0]   LP_RQ_FULL = (RQ_AW+1)'(P_REQ_DEPTH);
  localparam logic [RD_AW:0]   LP_RD_FULL = (RD_AW+1)'(P_RD_DEPTH);
  localparam logic [RD_AW+1:0] LP_RD_CRED = (RD_AW+2)'(P_RD_DEPTH);

  typedef struct packed {
    logic [1:0]  order;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] data;
  } req_t;

  req_t              r_req_mem [P_REQ_DEPTH];
  logic [RQ_AW-1:0]  r_req_wp, r_req_rp;
  logic [RQ_AW:0]    r_req_cnt;

  logic [63:0]       r_rd_mem [P_RD_DEPTH];
  logic [RD_AW-1:0]  r_rd_wp, r_rd_rp;
  logic [RD_AW:0]    r_rd_cnt;
  logic [RD_AW:0]    r_rd_out;

  logic              r_store_ack;
  logic              r_err;

  req_t              w_head;
  logic              w_req_ne, w_credit, w_push, w_pop;
  logic              w_rd_issue, w_wr_issue;
  logic              w_rd_ne, w_rd_full, w_ret_exp, w_ret_push, w_ret_err, w_rd_pop;
  logic [RD_AW+1:0]  w_cred_sum;

  assign w_head     = r_req_mem[r_req_rp];
  assign w_req_ne   = (r_req_cnt != '0);
  // Credit covers both reads in flight and data already parked in the return FIFO.
  assign w_cred_sum = {1'b0, r_rd_out} + {1'b0, r_rd_cnt};
  assign w_credit   = (w_cred_sum < LP_RD_CRED);

  assign oLOCK       = (r_req_cnt == LP_RQ_FULL);
  assign oMEMORY_REQ = w_req_ne && (w_head.rw || w_credit);

  assign w_push     = iREQ && !oLOCK;
  assign w_pop      = oMEMORY_REQ && !iMEMORY_LOCK;
  assign w_rd_issue = w_pop && !w_head.rw;
  assign w_wr_issue = w_pop && w_head.rw;

  // Head fields are masked while empty so the bus idles at zero.
  assign oMEMORY_ORDER = w_req_ne ? w_head.order : 2'b00;
  assign oMEMORY_RW    = w_req_ne ? w_head.rw    : 1'b0;
  assign oMEMORY_ADDR  = w_req_ne ? w_head.addr  : 32'h0;
  assign oMEMORY_DATA  = w_req_ne ? w_head.data  : 32'h0;

  assign w_rd_ne    = (r_rd_cnt != '0);
  assign w_rd_full  = (r_rd_cnt == LP_RD_FULL);
  assign w_ret_exp  = iMEMORY_VALID && (r_rd_out != '0);
  assign w_ret_push = w_ret_exp && !w_rd_full;
  assign w_ret_err  = iMEMORY_VALID && ((r_rd_out == '0) || w_rd_full);
  assign w_rd_pop   = w_rd_ne && !iBUSY;

  assign oVALID       = w_rd_ne;
  assign oDATA        = w_rd_ne ? r_rd_mem[r_rd_rp] : 64'h0;
  assign oMEMORY_BUSY = w_rd_full;
  assign oSTORE_ACK   = r_store_ack;
  assign oERR         = r_err;

  always_ff @(posedge iCLOCK) begin
    if (w_push) r_req_mem[r_req_wp] <= '{order: iORDER, rw: iRW, addr: iADDR, data: iDATA};
    if (w_ret_push) r_rd_mem[r_rd_wp] <= iMEMORY_DATA;
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      r_req_wp    <= '0;
      r_req_rp    <= '0;
      r_req_cnt   <= '0;
      r_rd_wp     <= '0;
      r_rd_rp     <= '0;
      r_rd_cnt    <= '0;
      r_rd_out    <= '0;
      r_store_ack <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      if (w_push) r_req_wp <= r_req_wp + 1'b1;
      if (w_pop)  r_req_rp <= r_req_rp + 1'b1;
      r_req_cnt <= r_req_cnt + (RQ_AW+1)'(w_push) - (RQ_AW+1)'(w_pop);

      if (w_ret_push) r_rd_wp <= r_rd_wp + 1'b1;
      if (w_rd_pop)   r_rd_rp <= r_rd_rp + 1'b1;
      r_rd_cnt <= r_rd_cnt + (RD_AW+1)'(w_ret_push) - (RD_AW+1)'(w_rd_pop);
      r_rd_out <= r_rd_out + (RD_AW+1)'(w_rd_issue) - (RD_AW+1)'(w_ret_exp);

      r_store_ack <= w_wr_issue;
      if (w_ret_err) r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_memory_request_buffer.sv
// Directed bench for memory_request_buffer with a fixed-latency memory responder.
module tb_memory_request_buffer;

  localparam logic [63:0] TAG = 64'hD0D0_0000_0000_0000;

  logic        iCLOCK = 1'b0;
  logic        inRESET;
  logic        iREQ, iRW, iBUSY, iMEMORY_LOCK;
  logic [1:0]  iORDER;
  logic [31:0] iADDR, iDATA;
  logic        iMEMORY_VALID;
  logic [63:0] iMEMORY_DATA;
  logic        oLOCK, oVALID, oSTORE_ACK, oMEMORY_REQ, oMEMORY_RW, oMEMORY_BUSY, oERR;
  logic [63:0] oDATA;
  logic [1:0]  oMEMORY_ORDER;
  logic [31:0] oMEMORY_ADDR, oMEMORY_DATA;

  logic        mem_auto, man_v;
  logic [63:0] man_d;
  logic        mv;
  logic [63:0] md;

  assign iMEMORY_VALID = mem_auto ? mv : man_v;
  assign iMEMORY_DATA  = mem_auto ? md : man_d;

  always #5 iCLOCK = ~iCLOCK;

  memory_request_buffer #(.P_REQ_DEPTH(4), .P_RD_DEPTH(4)) dut (
    .iCLOCK(iCLOCK), .inRESET(inRESET), .iREQ(iREQ), .oLOCK(oLOCK),
    .iORDER(iORDER), .iRW(iRW), .iADDR(iADDR), .iDATA(iDATA),
    .oVALID(oVALID), .iBUSY(iBUSY), .oDATA(oDATA), .oSTORE_ACK(oSTORE_ACK),
    .oMEMORY_REQ(oMEMORY_REQ), .iMEMORY_LOCK(iMEMORY_LOCK),
    .oMEMORY_ORDER(oMEMORY_ORDER), .oMEMORY_RW(oMEMORY_RW),
    .oMEMORY_ADDR(oMEMORY_ADDR), .oMEMORY_DATA(oMEMORY_DATA),
    .iMEMORY_VALID(iMEMORY_VALID), .oMEMORY_BUSY(oMEMORY_BUSY),
    .iMEMORY_DATA(iMEMORY_DATA), .oERR(oERR)
  );

  // Issue monitor and memory model: a read issued at edge E returns at edge E+3.
  int          cyc = 0;
  int          n_rd_iss = 0;
  int          n_wr_iss = 0;
  logic [31:0] wr_addr_q[$];
  int          wr_cyc_q[$];
  logic        rw_q[$];
  logic [2:0]  pv;
  logic [63:0] pd[3];

  always @(negedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      pv = 3'b000;
      mv = 1'b0;
      md = 64'h0;
    end else begin
      cyc++;
      mv = pv[2];
      md = pd[2];
      pv[2] = pv[1]; pd[2] = pd[1];
      pv[1] = pv[0]; pd[1] = pd[0];
      pv[0] = 1'b0;  pd[0] = 64'h0;
      if (oMEMORY_REQ && !iMEMORY_LOCK) begin
        rw_q.push_back(oMEMORY_RW);
        if (oMEMORY_RW) begin
          n_wr_iss++;
          wr_addr_q.push_back(oMEMORY_ADDR);
          wr_cyc_q.push_back(cyc);
        end else begin
          pv[0] = 1'b1;
          pd[0] = TAG | 64'(n_rd_iss);
          n_rd_iss++;
        end
      end
    end
  end

  int n_chk = 0;
  int n_fail = 0;
  int exp_seq = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge iCLOCK);
    #1;
  endtask

  task automatic push(input logic rw, input logic [1:0] ord, input logic [31:0] a, input logic [31:0] d);
    logic acc;
    acc = 1'b0;
    iRW = rw; iORDER = ord; iADDR = a; iDATA = d; iREQ = 1'b1;
    for (int i = 0; i < 50; i++) begin
      acc = !oLOCK;
      tick();
      if (acc) break;
    end
    iREQ = 1'b0;
    if (!acc) chk("push_timeout", {63'h0, acc}, 64'h1);
  endtask

  task automatic drain(input int n);
    int got;
    got = 0;
    iBUSY = 1'b0;
    for (int i = 0; i < 80 && got < n; i++) begin
      if (oVALID) begin
        chk("rd_data", oDATA, TAG | 64'(exp_seq));
        exp_seq++;
        got++;
      end
      tick();
    end
    if (got < n) chk("drain_timeout", 64'(got), 64'(n));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    inRESET = 1'b0; iREQ = 1'b0; iRW = 1'b0; iORDER = 2'b00; iADDR = '0; iDATA = '0;
    iBUSY = 1'b0; iMEMORY_LOCK = 1'b0; mem_auto = 1'b1; man_v = 1'b0; man_d = '0;
    #1;
    chk("rst_lock", oLOCK, 0);
    chk("rst_valid", oVALID, 0);
    chk("rst_mreq", oMEMORY_REQ, 0);
    chk("rst_mbusy", oMEMORY_BUSY, 0);
    chk("rst_ack", oSTORE_ACK, 0);
    chk("rst_err", oERR, 0);
    chk("rst_bus", {oMEMORY_ADDR, oMEMORY_DATA}, 64'h0);
    tick(); tick();
    inRESET = 1'b1;
    tick();

    // Single write
    push(1'b1, 2'b10, 32'h100, 32'hDEADBEEF);
    chk("sw_req", oMEMORY_REQ, 1);
    chk("sw_addr", oMEMORY_ADDR, 32'h100);
    chk("sw_data", oMEMORY_DATA, 32'hDEADBEEF);
    chk("sw_order", oMEMORY_ORDER, 2'b10);
    chk("sw_rw", oMEMORY_RW, 1);
    chk("sw_ack_early", oSTORE_ACK, 0);
    tick();
    chk("sw_req_drop", oMEMORY_REQ, 0);
    chk("sw_ack", oSTORE_ACK, 1);
    chk("sw_valid", oVALID, 0);
    tick();
    chk("sw_ack_clr", oSTORE_ACK, 0);

    // FIFO fill with memory locked
    iMEMORY_LOCK = 1'b1;
    base = wr_addr_q.size();
    for (int i = 0; i < 4; i++) begin
      chk("fill_lock_pre", oLOCK, 0);
      push(1'b1, 2'b10, 32'(i * 4), 32'(i));
    end
    chk("fill_lock", oLOCK, 1);
    iRW = 1'b1; iORDER = 2'b10; iADDR = 32'h10; iDATA = 32'h5; iREQ = 1'b1;
    tick();
    chk("fill_held", oLOCK, 1);
    chk("fill_no_iss", 64'(wr_addr_q.size() - base), 0);
    iMEMORY_LOCK = 1'b0;
    for (int i = 0; i < 10; i++) begin
      logic acc;
      acc = !oLOCK;
      tick();
      if (acc) break;
    end
    iREQ = 1'b0;
    repeat (6) tick();
    chk("fill_cnt", 64'(wr_addr_q.size() - base), 5);
    if (wr_addr_q.size() >= base + 5) begin
      for (int i = 0; i < 5; i++) chk("fill_addr", wr_addr_q[base + i], 32'(i * 4));
      for (int i = 0; i < 3; i++) chk("fill_b2b", 64'(wr_cyc_q[base + i + 1] - wr_cyc_q[base + i]), 1);
    end

    // Read credit
    iBUSY = 1'b1;
    exp_seq = n_rd_iss;
    for (int i = 0; i < 6; i++) push(1'b0, 2'b10, 32'h200 + 32'(i * 4), 32'h0);
    repeat (10) tick();
    chk("cred_iss4", 64'(n_rd_iss), 4);
    chk("cred_mbusy", oMEMORY_BUSY, 1);
    chk("cred_mreq", oMEMORY_REQ, 0);
    chk("cred_valid", oVALID, 1);
    drain(6);
    tick(); tick();
    chk("cred_iss6", 64'(n_rd_iss), 6);
    chk("cred_empty", oVALID, 0);
    chk("cred_err", oERR, 0);

    // Mixed ordering: write stuck behind a credit-blocked read
    iBUSY = 1'b1;
    for (int i = 0; i < 4; i++) push(1'b0, 2'b10, 32'h400 + 32'(i * 4), 32'h0);
    repeat (12) tick();
    chk("mix_full", oMEMORY_BUSY, 1);
    base = rw_q.size();
    push(1'b0, 2'b10, 32'h500, 32'h0);
    push(1'b1, 2'b10, 32'h504, 32'h55);
    push(1'b0, 2'b10, 32'h508, 32'h0);
    repeat (4) tick();
    chk("mix_blk_req", oMEMORY_REQ, 0);
    chk("mix_blk_iss", 64'(rw_q.size() - base), 0);
    chk("mix_blk_ack", oSTORE_ACK, 0);
    drain(6);
    repeat (4) tick();
    chk("mix_cnt", 64'(rw_q.size() - base), 3);
    if (rw_q.size() >= base + 3) begin
      chk("mix_ord0", rw_q[base], 0);
      chk("mix_ord1", rw_q[base + 1], 1);
      chk("mix_ord2", rw_q[base + 2], 0);
    end

    // Spurious return
    mem_auto = 1'b0;
    man_v = 1'b1; man_d = 64'hBAD0;
    tick();
    man_v = 1'b0;
    chk("sp_err", oERR, 1);
    chk("sp_valid", oVALID, 0);
    repeat (3) tick();
    chk("sp_err_sticky", oERR, 1);

    // Reset mid-burst: 2 reads outstanding, 3 writes queued
    push(1'b0, 2'b10, 32'h600, 32'h0);
    push(1'b0, 2'b10, 32'h604, 32'h0);
    tick(); tick();
    iMEMORY_LOCK = 1'b1;
    for (int i = 0; i < 3; i++) push(1'b1, 2'b10, 32'h700 + 32'(i * 4), 32'(i));
    chk("mr_pre_req", oMEMORY_REQ, 1);
    #2;
    inRESET = 1'b0;
    #1;
    chk("mr_lock", oLOCK, 0);
    chk("mr_valid", oVALID, 0);
    chk("mr_mreq", oMEMORY_REQ, 0);
    chk("mr_mbusy", oMEMORY_BUSY, 0);
    chk("mr_ack", oSTORE_ACK, 0);
    chk("mr_err", oERR, 0);
    chk("mr_bus", {oMEMORY_ADDR, oMEMORY_DATA}, 64'h0);
    tick();
    inRESET = 1'b1; iMEMORY_LOCK = 1'b0; mem_auto = 1'b1; iBUSY = 1'b0;
    tick();
    exp_seq = n_rd_iss;
    push(1'b0, 2'b10, 32'h800, 32'h0);
    chk("mr_rd_req", oMEMORY_REQ, 1);
    drain(1);
    tick(); tick();
    chk("mr_rd_done", oVALID, 0);
    chk("mr_rd_err", oERR, 0);
    chk("mr_idle", oMEMORY_REQ, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
